// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the core's decoder:
// opcode map, host op_sel codes, terminator word and loader FSM states.
package imem_program_loader_pkg;

    localparam logic [5:0] OPC_ADD = 6'b000001;
    localparam logic [5:0] OPC_LW  = 6'b000010;
    localparam logic [5:0] OPC_SW  = 6'b000100;

    localparam logic [1:0] OPSEL_ADD     = 2'd0;
    localparam logic [1:0] OPSEL_LW      = 2'd1;
    localparam logic [1:0] OPSEL_SW      = 2'd2;
    localparam logic [1:0] OPSEL_ILLEGAL = 2'd3;

    // Opcode 0 decodes as a no-op, so an all-zero word ends the program.
    localparam logic [31:0] TERMINATOR_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEAL = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/imem_program_loader_instr_encoder.sv
// Combinational encoder: decoded instruction fields to a 32-bit instruction word.
// An illegal op_sel yields an all-zero word; the loader never writes it.
module imem_program_loader_instr_encoder
    import imem_program_loader_pkg::*;
(
    input  logic [1:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (op_sel)
            OPSEL_ADD: word = {OPC_ADD, rs, rt, rd, 5'b0, 6'b0};
            OPSEL_LW:  word = {OPC_LW, rs, rt, imm};
            OPSEL_SW:  word = {OPC_SW, rs, rt, imm};
            default:   word = '0;
        endcase
    end

endmodule

// File: rtl/imem_program_loader.sv
// Loads encoded instructions sequentially into instruction memory, appends a
// terminator on request and pulses cpu_start once the program is sealed.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int DEPTH     = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic              finish,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal,
    output logic              cpu_start
);

    localparam int CNT_W = ADDR_W + 1;
    // Last slot is always held back for the terminator.
    localparam logic [CNT_W-1:0] RSV_LIMIT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                err_q, err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                start_q, start_d;
    logic                ready_q, ready_d;
    logic                term_q, term_d;
    logic [31:0]         enc_word;
    logic                accept;
    logic [ADDR_W-1:0]   next_addr;

    imem_program_loader_instr_encoder u_enc (
        .op_sel (op_sel),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .imm    (imm),
        .word   (enc_word)
    );

    assign accept    = in_valid && ready_q;
    assign next_addr = ADDR_W'(BASE_ADDR) + count_q[ADDR_W-1:0];

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        start_d = 1'b0;
        term_d  = term_q;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    if (op_sel == OPSEL_ILLEGAL) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = next_addr;
                        wdata_d = enc_word;
                        count_d = count_q + 1'b1;
                    end
                    state_d = ST_LOAD;
                end
                if (finish) begin
                    state_d = ST_SEAL;
                end
            end
            ST_SEAL: begin
                // First SEAL cycle writes the terminator, second releases the core.
                if (!term_q) begin
                    we_d    = 1'b1;
                    addr_d  = next_addr;
                    wdata_d = TERMINATOR_WORD;
                    count_d = count_q + 1'b1;
                    term_d  = 1'b1;
                end else begin
                    start_d = 1'b1;
                    term_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = ((state_d == ST_IDLE) || (state_d == ST_LOAD)) && (count_d < RSV_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            wdata_q <= '0;
            start_q <= 1'b0;
            ready_q <= 1'b0;
            term_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
            ready_q <= ready_d;
            term_q  <= term_d;
        end
    end

    assign in_ready    = ready_q;
    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign count       = count_q;
    assign full        = (count_q == FULL_CNT);
    assign err_illegal = err_q;
    assign cpu_start   = start_q;

endmodule
